// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and FSM encoding for the vectoring CORDIC engine
package cordic_pkg;

    localparam int ZW      = 18;
    localparam int ANGLE_W = 16;
    localparam int ATAN_AW = 5;
    localparam int ATAN_DW = 16;

    localparam logic signed [ZW-1:0] PI_HALF = 18'sh0C910;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/ATAN_ROM.sv
// ATAN_ROM: combinational table of atan(2^-i) in unsigned Q1.15, entries past 15 read as zero
module ATAN_ROM
    import cordic_pkg::*;
#(
    parameter string ATANLUT_FILENAME = "../simdata/atanLUT16.hex"
) (
    input  logic [ATAN_AW-1:0] addr,
    output logic [ATAN_DW-1:0] data
);

    // A ROM built without an initialisation image has blank contents.
    localparam bit LOADED = ATANLUT_FILENAME != "";

    localparam logic [ATAN_DW-1:0] LUT [16] = '{
        16'h6488, 16'h3B59, 16'h1F5B, 16'h0FEB,
        16'h07FD, 16'h0400, 16'h0200, 16'h0100,
        16'h0080, 16'h0040, 16'h0020, 16'h0010,
        16'h0008, 16'h0004, 16'h0002, 16'h0001
    };

    assign data = (LOADED && !addr[ATAN_AW-1]) ? LUT[addr[3:0]] : '0;

endmodule

// File: rtl/cordic_vector_seq.sv
// cordic_vector_seq: iterative vectoring-mode CORDIC, (x, y) -> magnitude and Q3.13 angle
module cordic_vector_seq
    import cordic_pkg::*;
#(
    parameter int    NITER            = 16,
    parameter int    DW               = 16,
    parameter int    GUARD            = 2,
    parameter string ATANLUT_FILENAME = "../simdata/atanLUT16.hex"
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [DW-1:0]      xin,
    input  logic signed [DW-1:0]      yin,
    output logic                      busy,
    output logic                      done,
    output logic        [DW+1:0]      modout,
    output logic signed [ANGLE_W-1:0] angle
);

    // Three integer headroom bits cover quadrant negation and the ~1.65 CORDIC gain.
    localparam int W = DW + 3 + GUARD;

    state_t                     state_q, state_d;
    logic        [ATAN_AW-1:0]  cnt_q, cnt_d;
    logic signed [W-1:0]        x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]       z_q, z_d;
    logic        [DW+1:0]       mod_q, mod_d;
    logic signed [ANGLE_W-1:0]  ang_q, ang_d;
    logic                       done_q, done_d;
    logic        [ATAN_AW-1:0]  rom_addr;
    logic        [ATAN_DW-1:0]  rom_data;
    logic signed [ZW-1:0]       atan_z;
    logic signed [W-1:0]        x_sh, y_sh;

    ATAN_ROM #(
        .ATANLUT_FILENAME(ATANLUT_FILENAME)
    ) u_rom (
        .addr(rom_addr),
        .data(rom_data)
    );

    assign rom_addr = (state_q == ITER) ? cnt_q : '0;
    assign atan_z   = {{(ZW-ATAN_DW){1'b0}}, rom_data};
    assign x_sh     = x_q >>> cnt_q;
    assign y_sh     = y_q >>> cnt_q;

    assign busy   = state_q != IDLE;
    assign done   = done_q;
    assign modout = mod_q;
    assign angle  = ang_q;

    // Next-state logic: operand capture, quadrant fold, micro-rotations, result load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mod_d   = mod_q;
        ang_d   = ang_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRE;
                    x_d     = {{3{xin[DW-1]}}, xin, {GUARD{1'b0}}};
                    y_d     = {{3{yin[DW-1]}}, yin, {GUARD{1'b0}}};
                    z_d     = '0;
                end
            end
            PRE: begin
                state_d = ITER;
                cnt_d   = '0;
                if (x_q[W-1]) begin
                    x_d = y_q[W-1] ? -y_q : y_q;
                    y_d = y_q[W-1] ? x_q : -x_q;
                    z_d = y_q[W-1] ? -PI_HALF : PI_HALF;
                end
            end
            ITER: begin
                x_d     = y_q[W-1] ? x_q - y_sh : x_q + y_sh;
                y_d     = y_q[W-1] ? y_q + x_sh : y_q - x_sh;
                z_d     = y_q[W-1] ? z_q - atan_z : z_q + atan_z;
                cnt_d   = (cnt_q == ATAN_AW'(NITER-1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == ATAN_AW'(NITER-1)) ? DONE : ITER;
            end
            DONE: begin
                state_d = IDLE;
                mod_d   = x_q[GUARD+DW+1:GUARD];
                ang_d   = z_q[ZW-1:2];
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mod_q   <= '0;
            ang_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mod_q   <= mod_d;
            ang_q   <= ang_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_cordic_vector_seq.sv
// tb_cordic_vector_seq: directed table, corner sequences and random vectors against a real-math model
module tb_cordic_vector_seq;

    localparam int NITER = 16;
    localparam int DW    = 16;
    localparam int LAT   = NITER + 2;
    localparam int PI_Q13     = 25736;
    localparam int TWO_PI_Q13 = 51472;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] xin = '0;
    logic signed [15:0] yin = '0;
    logic               busy;
    logic               done;
    logic        [17:0] modout;
    logic signed [15:0] angle;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int x;
        int y;
        int mod;
        int ang;
        int mtol;
        int atol;
    } vec_t;

    cordic_vector_seq #(
        .NITER(NITER),
        .DW(DW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .xin(xin),
        .yin(yin),
        .busy(busy),
        .done(done),
        .modout(modout),
        .angle(angle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        vectors++;
        if (d < -tol || d > tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    // Angles are compared modulo 2*pi so that +pi and -pi are treated as neighbours.
    task automatic chk_ang(input string name, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        if (d > PI_Q13) d -= TWO_PI_Q13;
        if (d < -PI_Q13) d += TWO_PI_Q13;
        vectors++;
        if (d < -tol || d > tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    // Issues one request and watches a fixed window; optionally pulses a second start after sample inj_n.
    task automatic run_op(input int x, input int y, input int inj_n, input int ix, input int iy,
                          output int mod, output int ang, output int lat,
                          output int dones, output int busy_bad);
        xin   = 16'(x);
        yin   = 16'(y);
        start = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        lat      = -1;
        dones    = 0;
        busy_bad = 0;
        mod      = 0;
        ang      = 0;
        for (int n = 1; n <= LAT + 6; n++) begin
            @(posedge clock);
            #1;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    mod = int'(modout);
                    ang = int'(angle);
                end
            end
            if (lat < 0 && !busy) busy_bad++;
            if (lat >= 0 && busy) busy_bad++;
            if (n == inj_n) begin
                xin   = 16'(ix);
                yin   = 16'(iy);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    function automatic real gain();
        real k;
        k = 1.0;
        for (int i = 0; i < NITER; i++) k = k * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        return k;
    endfunction

    initial begin
        vec_t tbl[6];
        int   mod, ang, lat, dones, bb, dd;
        int   x, y;
        real  k;

        tbl[0] = '{16384, 0, 26981, 0, 4, 2};
        tbl[1] = '{0, 16384, 26981, 12868, 4, 2};
        tbl[2] = '{-16384, 0, 26981, 25736, 4, 2};
        tbl[3] = '{10000, 10000, 23289, 6434, 4, 2};
        tbl[4] = '{-32768, -32768, 76315, -19302, 8, 2};
        tbl[5] = '{0, -16384, 26981, -12868, 4, 2};

        #12;
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_done", int'(done), 0, 0);
        chk("rst_mod", int'(modout), 0, 0);
        chk("rst_ang", int'(angle), 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].x, tbl[i].y, -1, 0, 0, mod, ang, lat, dones, bb);
            chk($sformatf("tbl%0d_mod", i), mod, tbl[i].mod, tbl[i].mtol);
            chk_ang($sformatf("tbl%0d_ang", i), ang, tbl[i].ang, tbl[i].atol);
            chk($sformatf("tbl%0d_lat", i), lat, LAT, 0);
            chk($sformatf("tbl%0d_dones", i), dones, 1, 0);
            chk($sformatf("tbl%0d_busy", i), bb, 0, 0);
        end

        run_op(0, 0, -1, 0, 0, mod, ang, lat, dones, bb);
        chk("zero_mod", mod, 0, 0);
        chk("zero_ang_x", int'($isunknown(angle)), 0, 0);
        chk("zero_lat", lat, LAT, 0);

        run_op(10000, 10000, 5, -5000, 3000, mod, ang, lat, dones, bb);
        chk("dbl_mod", mod, 23289, 4);
        chk_ang("dbl_ang", ang, 6434, 2);
        chk("dbl_lat", lat, LAT, 0);
        chk("dbl_dones", dones, 1, 0);
        chk("dbl_busy", bb, 0, 0);

        run_op(16384, 0, LAT - 1, -16384, 0, mod, ang, lat, dones, bb);
        chk_ang("lastcyc_ang", ang, 0, 2);
        chk("lastcyc_dones", dones, 1, 0);
        chk("lastcyc_busy", bb, 0, 0);

        xin   = 16'sd16384;
        yin   = 16'sd0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        chk("mid_busy_pre", int'(busy), 1, 0);
        reset = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0, 0);
        chk("midrst_done", int'(done), 0, 0);
        chk("midrst_mod", int'(modout), 0, 0);
        chk("midrst_ang", int'(angle), 0, 0);
        dd = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done || busy) dd++;
        end
        chk("midrst_quiet", dd, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        run_op(0, -16384, -1, 0, 0, mod, ang, lat, dones, bb);
        chk("postrst_mod", mod, 26981, 4);
        chk_ang("postrst_ang", ang, -12868, 2);
        chk("postrst_lat", lat, LAT, 0);
        chk("postrst_dones", dones, 1, 0);

        k = gain();
        for (int i = 0; i < 30; i++) begin
            do begin
                x = int'($urandom_range(0, 65535)) - 32768;
                y = int'($urandom_range(0, 65535)) - 32768;
            end while ((x < 0 ? -x : x) + (y < 0 ? -y : y) < 2048);
            run_op(x, y, -1, 0, 0, mod, ang, lat, dones, bb);
            chk($sformatf("rnd%0d_mod(%0d,%0d)", i, x, y), mod,
                int'(k * $sqrt(real'(x) * real'(x) + real'(y) * real'(y))), 8);
            chk_ang($sformatf("rnd%0d_ang(%0d,%0d)", i, x, y), ang,
                    int'($atan2(real'(y), real'(x)) * 8192.0), 4);
            chk($sformatf("rnd%0d_lat", i), lat, LAT, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
